matrix_feeder: RTL and testbench

MATRIX_FEEDER -- requirements
Module: matrix_feeder

---
 rtl/matrix_feeder.sv | 144 ++++++++++++++
 tb/tb_matrix_feeder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_feeder.sv
// Streams two 4x4 operand matrices into a systolic array, one (A,B) pair per beat.
// Beat n carries A row n/4 element n%4 and B column n/4 element n%4.
module matrix_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [3:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  read_data,
  input  logic                  done,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_in_A,
  output logic [DATA_WIDTH-1:0] data_in_B,
  output logic                  busy,
  output logic                  feed_done,
  output logic                  overrun
);

  localparam int NELEM = SIZE * SIZE;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_beat, w_beat_nxt;
  logic                  r_valid, w_valid_nxt;
  logic [DATA_WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic                  r_feed_done, w_feed_done_nxt;
  logic                  r_overrun, w_overrun_nxt;

  logic [DATA_WIDTH-1:0] r_mem_a [NELEM];
  logic [DATA_WIDTH-1:0] r_mem_b [NELEM];

  logic                  w_busy;
  logic                  w_wr_ok;
  logic [3:0]            w_idx;
  logic [3:0]            w_idx_b;
  logic [DATA_WIDTH-1:0] w_rd_a, w_rd_b;

  assign w_busy  = (r_state != S_IDLE);
  // Host writes only land in IDLE and never while reset is asserted.
  assign w_wr_ok = wr_en && !rst_n && !w_busy;

  // Operand storage has no reset so contents survive an aborted stream.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      if (wr_sel) r_mem_b[wr_addr] <= wr_data;
      else        r_mem_a[wr_addr] <= wr_data;
    end
  end

  // B is walked column-wise: index {k, r} where beat = {r, k}.
  assign w_idx_b = {w_idx[1:0], w_idx[3:2]};

  // Forward a same-cycle write so write+start streams the new value on beat 0.
  always_comb begin
    w_rd_a = r_mem_a[w_idx];
    w_rd_b = r_mem_b[w_idx_b];
    if (w_wr_ok && !wr_sel && (wr_addr == w_idx))   w_rd_a = wr_data;
    if (w_wr_ok &&  wr_sel && (wr_addr == w_idx_b)) w_rd_b = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_valid     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_feed_done <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_valid     <= w_valid_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_feed_done <= w_feed_done_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_valid_nxt     = r_valid;
    w_feed_done_nxt = 1'b0;
    w_overrun_nxt   = r_overrun || (w_busy && (start || wr_en));
    w_idx           = r_beat;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_STREAM;
          w_beat_nxt    = 4'd0;
          w_valid_nxt   = 1'b1;
          w_idx         = 4'd0;
          w_overrun_nxt = 1'b0;
        end
      end
      S_STREAM: begin
        if (r_valid && read_data) begin
          if (r_beat == 4'd15) begin
            // Counter parks at 15 until the next accepted start.
            w_state_nxt = S_WAIT;
            w_valid_nxt = 1'b0;
          end else begin
            w_beat_nxt = r_beat + 4'd1;
            w_idx      = r_beat + 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (done) begin
          w_state_nxt     = S_IDLE;
          w_feed_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase

    w_a_nxt = w_valid_nxt ? w_rd_a : '0;
    w_b_nxt = w_valid_nxt ? w_rd_b : '0;
  end

  assign data_valid = r_valid;
  assign data_in_A  = r_a;
  assign data_in_B  = r_b;
  assign busy       = w_busy;
  assign feed_done  = r_feed_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_matrix_feeder.sv
// Self-checking bench for matrix_feeder: randomized streams against a matrix-level model.
module tb_matrix_feeder;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, wr_sel, start, read_data, done;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          data_valid, busy, feed_done, overrun;
  logic [DW-1:0] data_in_A, data_in_B;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] ma [16];
  logic [DW-1:0] mb [16];
  logic [DW-1:0] got_a [16];
  logic [DW-1:0] got_b [16];
  logic          exp_ovr;

  matrix_feeder #(.DATA_WIDTH(DW), .SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .read_data(read_data), .done(done),
    .data_valid(data_valid), .data_in_A(data_in_A), .data_in_B(data_in_B),
    .busy(busy), .feed_done(feed_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0;
    start = 0; read_data = 0; done = 0;
  endtask

  task automatic wr(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
    wr_en = 1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick;
    wr_en = 0;
    if (sel) mb[addr] = data; else ma[addr] = data;
  endtask

  task automatic load_all(input int mode);
    for (int i = 0; i < 16; i++) begin
      wr(1'b0, 4'(i), (mode == 0) ? DW'(i + 1)  : DW'($urandom));
      wr(1'b1, 4'(i), (mode == 0) ? DW'(16 + i) : DW'($urandom));
    end
  endtask

  // Optionally combine a host write with the start strobe.
  task automatic do_start(input logic with_wr, input logic sel, input logic [3:0] addr,
                          input logic [DW-1:0] data);
    start = 1;
    if (with_wr) begin
      wr_en = 1; wr_sel = sel; wr_addr = addr; wr_data = data;
    end
    tick;
    start = 0; wr_en = 0;
    if (with_wr) begin
      if (sel) mb[addr] = data; else ma[addr] = data;
    end
    exp_ovr = 0;
    chk("ovr_clr_on_start", overrun, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, data_valid, 0);
    chk({tag, "_A"}, data_in_A, 0);
    chk({tag, "_B"}, data_in_B, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fdone"}, feed_done, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  // mode: 0 ready always, 1 toggling 1,0,..., 2 random. inj_at: cycle to inject
  // start+write(A[0]=0x55) while busy. abort_at: beat at which reset is applied.
  task automatic stream(input int mode, input int inj_at, input int abort_at, output int vcyc);
    int n   = 0;
    int cyc = 0;
    logic rd;
    vcyc = 0;
    while (n < 16 && cyc < 200) begin
      if (abort_at >= 0 && n == abort_at) begin
        rst_n = 1; read_data = 1; done = 0;
        wr_en = 1; wr_sel = 0; wr_addr = 4'd3; wr_data = ~ma[3];
        tick;
        rst_n = 0; wr_en = 0; read_data = 0;
        chk_reset_outs("abort");
        exp_ovr = 0;
        done = 1;
        tick;
        done = 0;
        chk("abort_no_fdone", feed_done, 0);
        chk("abort_idle", busy, 0);
        return;
      end
      rd = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      read_data = rd;
      done = 1'($urandom_range(0, 1));
      chk("s_valid", data_valid, 1);
      chk("s_A", data_in_A, ma[n]);
      chk("s_B", data_in_B, mb[4 * (n % 4) + n / 4]);
      chk("s_busy", busy, 1);
      chk("s_fdone", feed_done, 0);
      chk("s_ovr", overrun, exp_ovr);
      got_a[n] = data_in_A;
      got_b[n] = data_in_B;
      vcyc++;
      if (cyc == inj_at) begin
        start = 1; wr_en = 1; wr_sel = 0; wr_addr = 0; wr_data = 8'h55;
      end
      if (rd) n++;
      tick;
      start = 0; wr_en = 0;
      if (cyc == inj_at) exp_ovr = 1;
      cyc++;
    end
    read_data = 0; done = 0;
    chk("s_bound", (n == 16) ? 1 : 0, 1);
    chk("end_valid", data_valid, 0);
    chk("end_A", data_in_A, 0);
    chk("end_B", data_in_B, 0);
    chk("end_busy", busy, 1);
    chk("end_ovr", overrun, exp_ovr);
  endtask

  task automatic finish_wait(input int dly);
    for (int i = 0; i < dly; i++) begin
      done = 0;
      chk("w_busy", busy, 1);
      chk("w_fdone", feed_done, 0);
      chk("w_valid", data_valid, 0);
      tick;
    end
    done = 1;
    tick;
    done = 0;
    chk("fdone_pulse", feed_done, 1);
    chk("fdone_busy", busy, 0);
    tick;
    chk("fdone_one", feed_done, 0);
    chk("fdone_idle", busy, 0);
  endtask

  int vc;

  initial begin
    idle_inputs();
    exp_ovr = 0;
    rst_n = 1;
    tick; tick;
    chk_reset_outs("reset");
    rst_n = 0;
    tick;
    chk_reset_outs("post_reset");

    // Incrementing load, ready held high.
    load_all(0);
    do_start(0, 0, 0, 0);
    stream(0, -1, -1, vc);
    chk("d_b0A", got_a[0], 1);   chk("d_b0B", got_b[0], 16);
    chk("d_b1A", got_a[1], 2);   chk("d_b1B", got_b[1], 20);
    chk("d_b4A", got_a[4], 5);   chk("d_b4B", got_b[4], 17);
    chk("d_b15A", got_a[15], 16); chk("d_b15B", got_b[15], 31);
    chk("d_vcyc", vc, 16);
    finish_wait(2);

    // Toggling ready: each beat held once.
    do_start(0, 0, 0, 0);
    stream(1, -1, -1, vc);
    chk("t_vcyc", vc, 31);
    finish_wait(2);

    // Busy-time start/write: flagged, ignored.
    do_start(0, 0, 0, 0);
    stream(2, 5, -1, vc);
    finish_wait(1);
    chk("ovr_sticky", overrun, 1);
    do_start(1, 0, 0, 8'h55);
    chk("ovr_A0", data_in_A, 8'h55);
    stream(0, -1, -1, vc);
    finish_wait(0);

    // Reset mid-stream at beat 7, then restream retained storage.
    do_start(0, 0, 0, 0);
    stream(0, -1, 7, vc);
    do_start(0, 0, 0, 0);
    stream(2, -1, -1, vc);
    finish_wait(3);

    // Same-cycle write + start.
    do_start(1, 0, 0, 8'hAA);
    chk("wrstart_A0", data_in_A, 8'hAA);
    stream(0, -1, -1, vc);
    finish_wait(1);

    // Random matrices and random handshakes.
    for (int it = 0; it < 6; it++) begin
      load_all(1);
      do_start(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), DW'($urandom));
      stream(2, (it % 2 == 0) ? int'($urandom_range(0, 10)) : -1, -1, vc);
      finish_wait(int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
